// File: rtl/app_iseq_issuer_pkg.sv
// app_iseq_issuer_pkg: shared types and defaults for the instruction-sequence issuer.
//   INSTR_WIDTH       : controller instruction word width
//   DEF_BUF_DEPTH     : default instruction buffer depth (power of two)
//   DEF_START_TIMEOUT : default cycles allowed for processing_iseq to rise
//   state_t           : issuer FSM state encoding
package app_iseq_issuer_pkg;
    localparam int INSTR_WIDTH       = 32;
    localparam int DEF_BUF_DEPTH     = 64;
    localparam int DEF_START_TIMEOUT = 1024;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;
endpackage

// File: rtl/iseq_rdback_drain.sv
// iseq_rdback_drain: moves beats from a standard-mode readback FIFO into a valid/ready stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   fifo_empty        : readback FIFO empty
//   fifo_rden         : FIFO read strobe (data appears one cycle later)
//   fifo_data         : FIFO output data
//   valid/ready/data  : host-side beat stream
//   in_flight         : a read was issued last cycle and its data lands this cycle
module iseq_rdback_drain #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fifo_empty,
    output logic         fifo_rden,
    input  logic [W-1:0] fifo_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         in_flight
);
    // Reads only when the output register is free (or draining now), so a landing
    // beat never overwrites an unconsumed one; the strobe is held low under reset.
    assign fifo_rden = rst_n && !fifo_empty && !in_flight && (!valid || ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            valid     <= 1'b0;
            data      <= '0;
        end else begin
            in_flight <= fifo_rden;
            if (in_flight) begin
                data  <= fifo_data;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/app_iseq_issuer.sv
// app_iseq_issuer: buffers one host instruction sequence, issues it to the controller
// over app_en/app_ack, tracks processing_iseq and drains readback data to the host.
//   host_instr_*      : host instruction stream (valid/ready, last marks sequence end)
//   app_en/app_ack    : controller instruction handshake, app_instr is the word
//   iq_full           : controller queue full, blocks a new request
//   processing_iseq   : controller executing the sequence
//   rdback_fifo_*     : readback FIFO interface (standard mode)
//   host_rd_*         : readback beat stream to the host
//   busy, seq_done, err_timeout : status
// Optional: define ISSUER_STATS_EN to add stat_instr_cnt, stat_rd_cnt and stat_cycles.
module app_iseq_issuer
    import app_iseq_issuer_pkg::*;
#(
    parameter int DQ_WIDTH      = 64,
    parameter int BUF_DEPTH     = DEF_BUF_DEPTH,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_instr_valid,
    output logic                     host_instr_ready,
    input  logic [INSTR_WIDTH-1:0]   host_instr,
    input  logic                     host_instr_last,
    output logic                     app_en,
    input  logic                     app_ack,
    output logic [INSTR_WIDTH-1:0]   app_instr,
    input  logic                     iq_full,
    input  logic                     processing_iseq,
    input  logic                     rdback_fifo_empty,
    output logic                     rdback_fifo_rden,
    input  logic [DQ_WIDTH*8-1:0]    rdback_data,
    output logic                     host_rd_valid,
    input  logic                     host_rd_ready,
    output logic [DQ_WIDTH*8-1:0]    host_rd_data,
    output logic                     busy,
    output logic                     seq_done,
    output logic                     err_timeout
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]              stat_instr_cnt,
    output logic [15:0]              stat_rd_cnt,
    output logic [31:0]              stat_cycles
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    state_t                 state;
    logic [PW-1:0]          wr_ptr, rd_ptr, last_ptr, nxt;
    logic [TW-1:0]          tmo;
    logic [INSTR_WIDTH-1:0] mem [BUF_DEPTH];
    logic                   loading, accept, word_last, ack, in_flight;

    assign loading          = state == ST_IDLE || state == ST_LOAD;
    assign host_instr_ready = loading;
    assign busy             = state != ST_IDLE;
    assign accept           = host_instr_valid && loading;
    // The top slot always closes the sequence, so the buffer can never overflow.
    assign word_last        = host_instr_last || &wr_ptr;
    assign ack              = app_en && app_ack;
    assign nxt              = ack ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= host_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_ptr    <= '0;
            tmo         <= '0;
            app_en      <= 1'b0;
            app_instr   <= '0;
            seq_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        last_ptr <= wr_ptr;
                        state    <= word_last ? ST_ISSUE : ST_LOAD;
                        if (state == ST_IDLE) err_timeout <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (ack) rd_ptr <= rd_ptr + 1'b1;
                    if (ack && rd_ptr == last_ptr) begin
                        app_en <= 1'b0;
                        tmo    <= '0;
                        state  <= ST_WAIT_START;
                    end else if (!app_en || ack) begin
                        // A pending request is frozen until acked; iq_full only gates new ones.
                        app_en    <= !iq_full;
                        app_instr <= mem[nxt];
                    end
                end
                ST_WAIT_START: begin
                    if (processing_iseq) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo == TW'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!processing_iseq && rdback_fifo_empty && !in_flight && !host_rd_valid) begin
                        seq_done <= 1'b1;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    iseq_rdback_drain #(.W(DQ_WIDTH * 8)) u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(rdback_fifo_empty),
        .fifo_rden (rdback_fifo_rden),
        .fifo_data (rdback_data),
        .valid     (host_rd_valid),
        .ready     (host_rd_ready),
        .data      (host_rd_data),
        .in_flight (in_flight)
    );

`ifdef ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_instr_cnt <= '0;
            stat_rd_cnt    <= '0;
            stat_cycles    <= '0;
        end else if (accept && word_last) begin
            stat_instr_cnt <= '0;
            stat_rd_cnt    <= '0;
            stat_cycles    <= '0;
        end else begin
            if (ack) stat_instr_cnt <= stat_instr_cnt + 1'b1;
            if (host_rd_valid && host_rd_ready) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (!loading && !(&stat_cycles)) stat_cycles <= stat_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_app_iseq_issuer.sv
// tb_app_iseq_issuer: table-driven and randomized bench for app_iseq_issuer with
// a behavioural controller, readback FIFO and host model.
module tb_app_iseq_issuer;
    localparam int DQ  = 64;
    localparam int DW  = DQ * 8;
    localparam int STO = 1024;

    typedef struct {
        int n_words;
        int use_last;
        int ack_pct;
        int iq_pct;
        int hold_idx;
        int n_beats;
        int rd_mode;
        int proc_cycles;
        int exp_timeout;
    } rec_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          host_instr_valid = 0, host_instr_ready, host_instr_last = 0;
    logic [31:0]   host_instr = '0;
    logic          app_en, app_ack = 0, iq_full = 0, processing_iseq = 0;
    logic [31:0]   app_instr;
    logic          rdback_fifo_empty = 1, rdback_fifo_rden;
    logic [DW-1:0] rdback_data = '0, host_rd_data;
    logic          host_rd_valid, host_rd_ready = 0;
    logic          busy, seq_done, err_timeout;

    app_iseq_issuer #(.DQ_WIDTH(DQ), .BUF_DEPTH(64), .START_TIMEOUT(STO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_instr_valid(host_instr_valid), .host_instr_ready(host_instr_ready),
        .host_instr(host_instr), .host_instr_last(host_instr_last),
        .app_en(app_en), .app_ack(app_ack), .app_instr(app_instr), .iq_full(iq_full),
        .processing_iseq(processing_iseq),
        .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden),
        .rdback_data(rdback_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
        .busy(busy), .seq_done(seq_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, ack_cyc = 0, n_done = 0, hold_viol = 0, rden_viol = 0;
    int ack_pct = 100, iq_pct = 0, hold_idx = -1, hold_left = 0, rd_mode = 2, pat_i = 0;
    logic [31:0]   got_instr[$];
    logic [DW-1:0] got_rd[$], fifo_q[$], pend;
    logic          pend_v = 0, prev_en = 0, prev_ack = 0;
    logic [31:0]   prev_instr = '0;
    logic [3:0]    pat = 4'b1001;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Environment: controller, readback FIFO and host sink. Inputs change on the
    // falling edge; what the DUT will see at the next rising edge is sampled 1 unit before it.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_v) begin
                rdback_data = pend;
                pend_v = 0;
            end
            rdback_fifo_empty = (fifo_q.size() == 0);
            host_rd_ready = (rd_mode == 1) ? pat[pat_i] : (rd_mode == 2) ? 1'b1 : 1'($urandom_range(1));
            pat_i = (pat_i + 1) % 4;
            if (hold_left > 0 && app_en && got_instr.size() == hold_idx) begin
                iq_full = 1;
                app_ack = 0;
                hold_left--;
            end else begin
                iq_full = ($urandom_range(99) < iq_pct);
                app_ack = app_en ? ($urandom_range(99) < ack_pct) : ($urandom_range(7) == 0);
            end
            #4;
            cyc++;
            if (!rst_n) begin
                prev_en = 0;
                prev_ack = 0;
            end else begin
                if (prev_en && !prev_ack && (!app_en || app_instr != prev_instr)) hold_viol++;
                if (rdback_fifo_rden && rdback_fifo_empty) rden_viol++;
                if (app_en && app_ack) begin
                    got_instr.push_back(app_instr);
                    ack_cyc = cyc;
                end
                if (host_rd_valid && host_rd_ready) got_rd.push_back(host_rd_data);
                if (seq_done) n_done++;
                if (rdback_fifo_rden && fifo_q.size() > 0) begin
                    pend = fifo_q.pop_front();
                    pend_v = 1;
                end
                prev_en = app_en;
                prev_ack = app_en && app_ack;
                prev_instr = app_instr;
            end
        end
    end

    task automatic load_words(input logic [31:0] w[$], input int use_last);
        int guard;
        for (int i = 0; i < w.size(); i++) begin
            @(negedge clk);
            guard = 0;
            while (!host_instr_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            host_instr_valid = 1;
            host_instr = w[i];
            host_instr_last = (use_last != 0) && (i == w.size() - 1);
        end
        @(negedge clk);
        host_instr_valid = 0;
        host_instr_last = 0;
    endtask

    task automatic run_rec(input rec_t r, input bit fixed);
        logic [31:0]   words[$];
        logic [DW-1:0] beats[$];
        int guard, viol;
        got_instr.delete();
        got_rd.delete();
        n_done = 0;
        hold_viol = 0;
        rden_viol = 0;
        ack_pct = r.ack_pct;
        iq_pct = r.iq_pct;
        hold_idx = r.hold_idx;
        hold_left = (r.hold_idx >= 0) ? 5 : 0;
        rd_mode = r.rd_mode;
        for (int i = 0; i < r.n_words; i++) words.push_back(fixed ? 32'(i + 1) : $urandom);
        load_words(words, r.use_last);
        chk("err_clear", err_timeout, 0);
        chk("rdy_in_issue", host_instr_ready, 0);
        chk("busy_issue", busy, 1);
        viol = 0;
        guard = 0;
        while (got_instr.size() < r.n_words && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (host_instr_ready) viol++;
        end
        chk("rdy_viol", viol, 0);
        chk("instr_cnt", got_instr.size(), r.n_words);
        viol = 0;
        foreach (words[i]) if (i >= got_instr.size() || got_instr[i] !== words[i]) viol++;
        chk("instr_seq", viol, 0);
        chk("hold_viol", hold_viol, 0);
        if (r.exp_timeout != 0) begin
            guard = 0;
            while (!err_timeout && guard < STO + 50) begin
                @(negedge clk);
                guard++;
            end
            // err_timeout is registered on the STO-th edge after the final ack.
            chk("to_cycles", cyc - ack_cyc, STO);
            chk("to_busy", busy, 0);
            chk("to_ready", host_instr_ready, 1);
            repeat (5) @(negedge clk);
            chk("to_no_done", n_done, 0);
            chk("to_sticky", err_timeout, 1);
        end else begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            processing_iseq = 1;
            for (int i = 0; i < r.n_beats; i++) begin
                beats.push_back(rnd_beat());
                fifo_q.push_back(beats[i]);
            end
            repeat (r.proc_cycles) @(negedge clk);
            chk("done_early", n_done, 0);
            processing_iseq = 0;
            guard = 0;
            while (n_done == 0 && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            chk("rd_at_done", got_rd.size(), r.n_beats);
            repeat (3) @(negedge clk);
            chk("done_cnt", n_done, 1);
            chk("busy_end", busy, 0);
            viol = 0;
            foreach (beats[i]) if (i >= got_rd.size() || got_rd[i] !== beats[i]) viol++;
            chk("rd_seq", viol, 0);
            chk("rd_cnt", got_rd.size(), r.n_beats);
        end
        chk("rden_viol", rden_viol, 0);
        chk("no_extra", got_instr.size(), r.n_words);
    endtask

    initial begin
        rec_t tbl[7];
        rec_t r;
        logic [31:0]   w3[$];
        logic [DW-1:0] b0;
        int guard;
        //            words last ack iq hold beats rd proc to
        tbl[0] = '{3,  1, 100, 0,  -1, 0, 2, 10, 0};
        tbl[1] = '{3,  1, 100, 0,   1, 0, 2,  5, 0};
        tbl[2] = '{64, 0,  80, 20, -1, 2, 2,  3, 0};
        tbl[3] = '{2,  1, 100, 0,  -1, 0, 2,  0, 1};
        tbl[4] = '{1,  1, 100, 0,  -1, 4, 1, 10, 0};
        tbl[5] = '{20, 1,  50, 30, -1, 9, 0, 20, 0};
        tbl[6] = '{40, 1,  70, 10,  7, 6, 0,  4, 0};

        b0 = rnd_beat();
        fifo_q.push_back(b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", host_instr_ready, 1);
        chk("rst_app_en", app_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_rd_valid", host_rd_valid, 0);
        chk("rst_rden", rdback_fifo_rden, 0);
        rst_n = 1;
        guard = 0;
        while (got_rd.size() == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("first_beat", (got_rd.size() == 1 && got_rd[0] === b0) ? 1 : 0, 1);

        for (int i = 0; i < 7; i++) run_rec(tbl[i], i == 0);

        for (int i = 0; i < 6; i++) begin
            r.n_words = $urandom_range(1, 64);
            r.use_last = (r.n_words < 64) ? 1 : $urandom_range(1);
            r.ack_pct = $urandom_range(30, 100);
            r.iq_pct = $urandom_range(0, 50);
            r.hold_idx = (r.n_words > 1 && $urandom_range(1) == 1) ? $urandom_range(1, r.n_words - 1) : -1;
            r.n_beats = $urandom_range(0, 8);
            r.rd_mode = $urandom_range(0, 2);
            r.proc_cycles = $urandom_range(1, 30);
            r.exp_timeout = 0;
            run_rec(r, 0);
        end

        // Reset in the middle of ISSUE with an outstanding request.
        ack_pct = 0;
        iq_pct = 0;
        hold_left = 0;
        for (int i = 0; i < 3; i++) w3.push_back($urandom);
        load_words(w3, 1);
        guard = 0;
        while (!app_en && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_issue_en", app_en, 1);
        #2 rst_n = 0;
        #1;
        chk("async_app_en", app_en, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", host_instr_ready, 1);
        chk("post_rst_app_en", app_en, 0);
        run_rec(tbl[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/app_iseq_issuer.md
Name: app_iseq_issuer

Overview:
Host-side initiator for the memory controller's app command interface and the consumer of its readback FIFO.
- Buffers one instruction sequence from the host (PCIe/UART bridge).
- Streams that sequence into the controller with the app_en/app_ack handshake.
- Tracks sequence execution through processing_iseq.
- Drains readback data into a valid/ready host stream.
- Sits between the host bridge and the controller top level.

Parameters:
DQ_WIDTH, 64, DRAM data width; readback beat is DQ_WIDTH*8 bits
BUF_DEPTH, 64, instruction buffer entries (power of two); pointer width is clog2(BUF_DEPTH)
START_TIMEOUT, 1024, cycles allowed from the last ack until processing_iseq rises

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
host_instr_valid  in  1  host instruction word valid
host_instr_ready  out  1  buffer can accept a word
host_instr  in  32  instruction word
host_instr_last  in  1  final word of the sequence
app_en  out  1  instruction request to the controller
app_ack  in  1  single-cycle acceptance from the controller
app_instr  out  32  instruction presented to the controller
iq_full  in  1  controller instruction queue full
processing_iseq  in  1  controller executing a sequence
rdback_fifo_empty  in  1  readback FIFO empty
rdback_fifo_rden  out  1  readback FIFO read strobe; data valid 1 cycle later (standard-mode FIFO)
rdback_data  in  DQ_WIDTH*8  readback FIFO output
host_rd_valid  out  1  readback beat valid to host
host_rd_ready  in  1  host accepts the beat
host_rd_data  out  DQ_WIDTH*8  readback beat
busy  out  1  state is not IDLE
seq_done  out  1  one-cycle pulse when a sequence completes
err_timeout  out  1  sticky flag; cleared by the next accepted first word or by reset

Behaviour:
- Reset values: all outputs are 0 except host_instr_ready, which is 1. Pointers, counters and the FSM state are cleared.
- FSM states are LOAD, ISSUE, WAIT_START, WAIT_DONE and IDLE. IDLE is the reset state and behaves as LOAD.
- IDLE/LOAD:
  - Write a word when host_instr_valid && host_instr_ready; write pointer increments.
  - host_instr_ready = 0 when the buffer is full or while in ISSUE, WAIT_START or WAIT_DONE.
  - A word accepted with last=1 moves the FSM to ISSUE.
  - The word written at index BUF_DEPTH-1 is treated as last regardless of host_instr_last.
- ISSUE:
  - Assert app_en with app_instr = buf[rd_ptr] only when iq_full=0.
  - Once app_en is asserted, app_en and app_instr stay stable until app_ack is sampled high, even if iq_full rises.
  - On app_ack, rd_ptr increments. The next word may be presented in the following cycle, giving back-to-back issue at 1 instruction/cycle.
  - app_ack without app_en is ignored.
  - Ack of the last word moves the FSM to WAIT_START with the timeout counter at 0.
- WAIT_START:
  - processing_iseq=1 moves the FSM to WAIT_DONE.
  - If the counter reaches START_TIMEOUT-1, set err_timeout and go to IDLE; no seq_done is issued.
- WAIT_DONE: go to IDLE and pulse seq_done when all of the following hold in one cycle:
  - processing_iseq=0
  - rdback_fifo_empty=1
  - no read in flight
  - host_rd_valid=0
- On entry to IDLE, both pointers clear.
- Readback drain runs independently of the FSM, in every state:
  - Pulse rdback_fifo_rden when rdback_fifo_empty=0, the output register is empty or being consumed this cycle, and no read is in flight.
  - The next cycle, capture rdback_data and set host_rd_valid.
  - host_rd_valid clears on host_rd_ready unless a new beat lands in the same cycle.
  - Sustained rate is 1 beat per 2 cycles; no beat may ever be dropped or duplicated.
- Reset asserted mid-sequence aborts immediately. Buffer contents are discarded and app_en drops asynchronously.

Optional Feature:
- Macro ISSUER_STATS_EN.
- When defined, three outputs are added, each clearing on entry to ISSUE:
  - stat_instr_cnt[15:0]: acks received in the sequence.
  - stat_rd_cnt[15:0]: readback beats delivered to the host.
  - stat_cycles[31:0]: cycles from ISSUE entry to the seq_done pulse; saturates at all ones.
- When not defined, these ports and their counters are absent and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - INSTR_WIDTH=32.
  - Default BUF_DEPTH and START_TIMEOUT.
- One sub-module: iseq_rdback_drain, covering the rden/output-register/valid-ready logic.
- The buffer is inferred distributed RAM inside the top.

Test Plan:
- Load 3 words (0x1,0x2,0x3 with last on 0x3), app_ack one cycle after each app_en, iq_full=0 → app_instr sequence 0x1,0x2,0x3 with app_en continuous; processing_iseq pulses for 10 cycles → seq_done after it falls.
- Raise iq_full while app_en=1 on word 2 and hold it for 5 cycles before acking → app_en/app_instr held stable; no word skipped or repeated.
- Load 64 words with last never asserted → ISSUE entered after word 63; host_instr_ready=0 throughout ISSUE; 64 acks observed.
- Never raise processing_iseq after the last ack → err_timeout=1 at cycle 1024; FSM in IDLE; no seq_done; next first word clears err_timeout.
- Readback FIFO holds 4 beats, host_rd_ready toggles 1,0,0,1 → 4 beats delivered in order, no duplicates; rden never asserted while empty=1.
- Assert rst_n=0 mid-ISSUE → app_en=0 in the same cycle; after release, busy=0 and host_instr_ready=1.
